// File: rtl/cmul_datapath.sv
// Complex-multiply datapath: one shared signed multiplier and one add/sub unit, sequenced by external strobes.
// Optional macro CMUL_OVF_EN adds o_ovf, flagging results that do not fit in 2W signed bits.
module cmul_datapath #(
  parameter int W  = 8,
  parameter int RW = 2*W+1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_ie,
  input  logic signed [W-1:0]  i_a_r,
  input  logic signed [W-1:0]  i_a_i,
  input  logic signed [W-1:0]  i_b_r,
  input  logic signed [W-1:0]  i_b_i,
  input  logic                 i_a_sel,
  input  logic                 i_b_sel,
  input  logic                 i_pp1_ce,
  input  logic                 i_pp2_ce,
  input  logic                 i_sub,
  input  logic                 i_p_r_ce,
  input  logic                 i_p_i_ce,
  output logic signed [RW-1:0] o_p_r,
  output logic signed [RW-1:0] o_p_i,
  output logic                 o_busy,
  output logic                 o_done
`ifdef CMUL_OVF_EN
  ,
  output logic                 o_ovf
`endif
);

  logic signed [W-1:0]    r_a_r, r_a_i, r_b_r, r_b_i;
  logic signed [2*W-1:0]  r_pp1, r_pp2;
  logic signed [RW-1:0]   r_p_r, r_p_i;
  logic                   r_busy, r_done;

  logic signed [W-1:0]    w_op_a, w_op_b;
  logic signed [2*W-1:0]  w_a_ext, w_b_ext, w_prod;
  logic signed [RW-1:0]   w_pp1_ext, w_pp2_ext, w_sum;
  logic                   w_start, w_finish;

  assign w_start  = i_ie && !r_busy;
  assign w_finish = i_p_i_ce && r_busy;

  // Idle: live ports, so the start-cycle ar*br product needs no captured copy.
  assign w_op_a = r_busy ? (i_a_sel ? r_a_i : r_a_r) : (i_a_sel ? i_a_i : i_a_r);
  assign w_op_b = r_busy ? (i_b_sel ? r_b_i : r_b_r) : (i_b_sel ? i_b_i : i_b_r);

  assign w_a_ext = {{W{w_op_a[W-1]}}, w_op_a};
  assign w_b_ext = {{W{w_op_b[W-1]}}, w_op_b};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_pp1_ext = {{(RW-2*W){r_pp1[2*W-1]}}, r_pp1};
  assign w_pp2_ext = {{(RW-2*W){r_pp2[2*W-1]}}, r_pp2};

  // Only a clean logic 1 subtracts; z/x fall through to the add path.
  always_comb begin
    w_sum = w_pp1_ext + w_pp2_ext;
    if (i_sub == 1'b1) w_sum = w_pp1_ext - w_pp2_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_r  <= '0;
      r_a_i  <= '0;
      r_b_r  <= '0;
      r_b_i  <= '0;
      r_pp1  <= '0;
      r_pp2  <= '0;
      r_p_r  <= '0;
      r_p_i  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_start) begin
        r_a_r  <= i_a_r;
        r_a_i  <= i_a_i;
        r_b_r  <= i_b_r;
        r_b_i  <= i_b_i;
        r_busy <= 1'b1;
      end else if (w_finish) begin
        r_busy <= 1'b0;
      end
      if (i_pp1_ce) r_pp1 <= w_prod;
      if (i_pp2_ce) r_pp2 <= w_prod;
      if (i_p_r_ce) r_p_r <= w_sum;
      if (i_p_i_ce) r_p_i <= w_sum;
      r_done <= w_finish;
    end
  end

  assign o_p_r  = r_p_r;
  assign o_p_i  = r_p_i;
  assign o_busy = r_busy;
  assign o_done = r_done;

`ifdef CMUL_OVF_EN
  logic signed [RW-1:0] w_pr_next;
  logic                 w_pr_ok, w_pi_ok, r_ovf;

  // Judge the pair as it will stand after this edge; p_i is always being loaded here.
  assign w_pr_next = i_p_r_ce ? w_sum : r_p_r;
  assign w_pr_ok   = (&w_pr_next[RW-1:2*W-1]) || !(|w_pr_next[RW-1:2*W-1]);
  assign w_pi_ok   = (&w_sum[RW-1:2*W-1])     || !(|w_sum[RW-1:2*W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ovf <= 1'b0;
    else if (w_finish) r_ovf <= !(w_pr_ok && w_pi_ok);
  end

  assign o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_cmul_datapath.sv
// Scoreboard bench for cmul_datapath: drives the 5-step strobe sequence, checks results on each done pulse.
module tb_cmul_datapath;
  localparam int W  = 8;
  localparam int RW = 2*W+1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 ie = 1'b0;
  logic signed [W-1:0]  a_r = '0, a_i = '0, b_r = '0, b_i = '0;
  logic                 a_sel = 1'b0, b_sel = 1'b0, pp1_ce = 1'b0, pp2_ce = 1'b0;
  logic                 sub = 1'b0, p_r_ce = 1'b0, p_i_ce = 1'b0;
  logic signed [RW-1:0] p_r, p_i;
  logic                 busy, done;
`ifdef CMUL_OVF_EN
  logic                 ovf;
`endif

  cmul_datapath #(.W(W), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .i_ie(ie),
    .i_a_r(a_r), .i_a_i(a_i), .i_b_r(b_r), .i_b_i(b_i),
    .i_a_sel(a_sel), .i_b_sel(b_sel), .i_pp1_ce(pp1_ce), .i_pp2_ce(pp2_ce),
    .i_sub(sub), .i_p_r_ce(p_r_ce), .i_p_i_ce(p_i_ce),
    .o_p_r(p_r), .o_p_i(p_i), .o_busy(busy), .o_done(done)
`ifdef CMUL_OVF_EN
    , .o_ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int r; int i; bit ov;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0, n_bad = 0;
  int   done_seen = 0, done_exp = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("p_r", p_r, mon_e.r);
        chk("p_i", p_i, mon_e.i);
        chk("xfree", longint'($isunknown({p_r, p_i})), 0);
`ifdef CMUL_OVF_EN
        chk("ovf", ovf, mon_e.ov);
`endif
        $display("op done: p_r=%0d p_i=%0d (exp %0d %0d)", p_r, p_i, mon_e.r, mon_e.i);
      end
    end
  end

  task automatic strobes(input bit as, input bit bs, input bit c1, input bit c2,
                         input logic s, input bit cr, input bit ci);
    a_sel = as; b_sel = bs; pp1_ce = c1; pp2_ce = c2;
    sub = s; p_r_ce = cr; p_i_ce = ci;
  endtask

  task automatic jitter_inputs();
    a_r = W'($urandom); a_i = W'($urandom);
    b_r = W'($urandom); b_i = W'($urandom);
  endtask

  // mode: 0 normal, 1 inputs/ie toggle while busy, 2 sub left at z outside C2
  task automatic drive_op(input int ar, input int ai, input int br, input int bi, input int mode);
    exp_t e;
    logic sq;
    e.r  = ar*br - ai*bi;
    e.i  = ar*bi + ai*br;
    e.ov = (e.r < -32768) || (e.r > 32767) || (e.i < -32768) || (e.i > 32767);
    sb.push_back(e);
    done_exp++;
    sq = (mode == 2) ? 1'bz : 1'b0;
    a_r = W'(ar); a_i = W'(ai); b_r = W'(br); b_i = W'(bi);
    ie = 1'b1;
    strobes(0, 0, 1, 0, sq, 0, 0);
    @(negedge clk);
    chk("busy_c1", busy, 1);
    chk("done_c1", done, 0);
    ie = (mode == 1);
    if (mode == 1) jitter_inputs();
    strobes(1, 1, 0, 1, sq, 0, 0);
    @(negedge clk);
    chk("busy_c2", busy, 1);
    ie = 1'b0;
    if (mode == 1) jitter_inputs();
    strobes(0, 1, 1, 0, 1'b1, 1, 0);
    @(negedge clk);
    chk("busy_c3", busy, 1);
    ie = (mode == 1);
    if (mode == 1) jitter_inputs();
    strobes(1, 0, 0, 1, sq, 0, 0);
    @(negedge clk);
    chk("busy_c4", busy, 1);
    chk("done_c4", done, 0);
    ie = 1'b0;
    if (mode == 1) jitter_inputs();
    strobes(0, 0, 0, 0, 1'b0, 0, 1);
    @(negedge clk);
    chk("busy_c5", busy, 0);
    chk("done_c5", done, 1);
    strobes(0, 0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic idle(input int n);
    ie = 1'b0;
    strobes(0, 0, 0, 0, 1'b0, 0, 0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("done_idle", done, 0);
    end
  endtask

  task automatic abort_op(input int ar, input int ai, input int br, input int bi);
    a_r = W'(ar); a_i = W'(ai); b_r = W'(br); b_i = W'(bi);
    ie = 1'b1;
    strobes(0, 0, 1, 0, 1'b0, 0, 0);
    @(negedge clk);
    ie = 1'b0;
    strobes(1, 1, 0, 1, 1'b0, 0, 0);
    @(negedge clk);
    strobes(0, 1, 1, 0, 1'b1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_p_r", p_r, 0);
    chk("rst_p_i", p_i, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    strobes(0, 0, 0, 0, 1'b0, 0, 0);
    rst_n = 1'b1;
    idle(5);
    chk("busy_after_abort", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_p_r", p_r, 0);
    chk("reset_p_i", p_i, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    drive_op(3, 4, 5, 6, 0);
    idle(2);
    drive_op(-128, -128, -128, -128, 0);
    drive_op(127, 0, 127, 0, 0);
    idle(1);
    drive_op(-77, 45, 100, -3, 1);
    idle(1);
    drive_op(12, -34, 56, -78, 2);
    idle(1);
    abort_op(9, 9, 9, 9);
    drive_op(7, -8, 9, 10, 0);
    idle(1);
    drive_op(20, 30, -40, 50, 0);
    drive_op(1, 1, 1, -1, 0);
    idle(2);
    for (int n = 0; n < 4; n++) begin
      drive_op(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, n % 3);
    end
    idle(3);

    chk("done_count", done_seen, done_exp);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
